// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter
// Description : Multi-cycle variable-amount shift unit for the ALU datapath.
//               Moves up to STEP bits per clock until the requested amount
//               has been consumed, then publishes the result on dout with a
//               one-cycle done pulse. Modes: SLL, SRL, SRA, ROR.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    data width in bits (power of two, >= 2)
//   SHAMT_W  shift-amount width, equal to $clog2(WIDTH)
//   STEP     bits shifted per cycle (power of two, 1..WIDTH)
// Ports
//   clk    in   1        clock, rising edge
//   rst_n  in   1        asynchronous reset, active-low
//   start  in   1        request, accepted only while ready=1
//   A      in   SHAMT_W  shift amount, sampled on accept
//   B      in   WIDTH    operand, sampled on accept
//   ctrl   in   2        00=SLL 01=SRL 10=SRA 11=ROR, sampled on accept
//   dout   out  WIDTH    result register, held until the next completion
//   busy   out  1        operation in progress
//   ready  out  1        ~busy, start is accepted this cycle
//   done   out  1        one-cycle pulse, dout newly updated
// ============================================================================
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SHAMT_W-1:0] A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         ctrl,
  output logic [WIDTH-1:0]   dout,
  output logic               busy,
  output logic               ready,
  output logic               done
);

  // Mode encodings of ctrl
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // One extra bit so that STEP == WIDTH and WIDTH itself are representable
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] rem_q,   rem_d;
  logic [1:0]         mode_q,  mode_d;
  logic [WIDTH-1:0]   dout_q,  dout_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;

  // --------------------------------------------------------------------------
  // Per-cycle shift datapath
  // --------------------------------------------------------------------------
  logic               rem_lt_step;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W:0]   ror_back;
  logic [WIDTH-1:0]   sll_val;
  logic [WIDTH-1:0]   srl_val;
  logic [WIDTH-1:0]   sra_val;
  logic [WIDTH-1:0]   ror_val;
  logic [WIDTH-1:0]   shifted;

  // Amount moved this cycle is min(STEP, rem). When STEP == WIDTH the
  // remaining amount is always smaller, so the truncated STEP value is
  // never selected in that configuration.
  assign rem_lt_step = ({1'b0, rem_q} < STEP_C);
  assign step_amt    = rem_lt_step ? rem_q : STEP_C[SHAMT_W-1:0];

  assign sll_val = shreg_q << step_amt;
  assign srl_val = shreg_q >> step_amt;
  // The running register keeps its MSB under an arithmetic shift, so the
  // sign bit filled in is always the operand MSB latched at accept.
  assign sra_val = $unsigned($signed(shreg_q) >>> step_amt);
  // Rotate right: bits dropped from the LSB end come back at the MSB end.
  // step_amt is non-zero whenever this value is used, so the back-shift
  // stays below WIDTH.
  assign ror_back = WIDTH_C - {1'b0, step_amt};
  assign ror_val  = (shreg_q >> step_amt) | (shreg_q << ror_back);

  always_comb begin
    shifted = shreg_q;
    case (mode_q)
      MODE_SLL: shifted = sll_val;
      MODE_SRL: shifted = srl_val;
      MODE_SRA: shifted = sra_val;
      MODE_ROR: shifted = ror_val;
      default:  shifted = shreg_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    done_d  = 1'b0;

    case (state_q)
      // DONE accepts like IDLE, which gives back-to-back operation without
      // an idle bubble when start is held.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shreg_d = B;
          rem_d   = A;
          mode_d  = ctrl;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (rem_q != '0) begin
          shreg_d = shifted;
          rem_d   = rem_q - step_amt;
        end else begin
          // Publish on the edge that enters DONE; done is registered so it
          // is high for exactly the DONE cycle.
          dout_d  = shreg_q;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dout  = dout_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign ready = ~busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shifter
// Description : Directed self-checking bench for iter_shifter. Instance u1
//               uses STEP=1, instance u4 uses STEP=4; both WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shifter;

  logic        clk;
  logic        rst_n;

  logic        start1, start4;
  logic [4:0]  a1, a4;
  logic [31:0] b1, b4;
  logic [1:0]  ctrl1, ctrl4;
  logic [31:0] dout1, dout4;
  logic        busy1, busy4, ready1, ready4, done1, done4;

  int checks;
  int failures;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .ctrl(ctrl1),
    .dout(dout1), .busy(busy1), .ready(ready1), .done(done1)
  );

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .ctrl(ctrl4),
    .dout(dout4), .busy(busy4), .ready(ready4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-at-a-time reference shifter
  function automatic logic [31:0] model(input logic [31:0] b, input int amt,
                                        input logic [1:0] c);
    logic [31:0] r;
    r = b;
    for (int i = 0; i < amt; i++) begin
      case (c)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {b[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  // Issue one op on u1 and wait for done. lat is the edge number (accept
  // edge = 0) after which done is first seen, -1 on timeout. busy_ok
  // records that busy stayed high from edge 0 until the done edge.
  // Operand inputs are scrambled right after accept.
  task automatic op1(input logic [4:0] sa, input logic [31:0] sb,
                     input logic [1:0] sc, output logic [31:0] res,
                     output int lat, output bit busy_ok);
    @(negedge clk);
    start1 = 1'b1; a1 = sa; b1 = sb; ctrl1 = sc;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = ~sa; b1 = ~sb; ctrl1 = ~sc;
    busy_ok = (busy1 === 1'b1);
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin lat = e; break; end
      if (busy1 !== 1'b1) busy_ok = 1'b0;
    end
    res = dout1;
  endtask

  task automatic op4(input logic [4:0] sa, input logic [31:0] sb,
                     input logic [1:0] sc, output logic [31:0] res,
                     output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = sa; b4 = sb; ctrl4 = sc;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~sa; b4 = ~sb; ctrl4 = ~sc;
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin lat = e; break; end
    end
    res = dout4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout1 !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=%h", dout1, 32'h0); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
    checks++; if (dout4 !== 32'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++; $display("FAIL reset_u4 got dout=%h busy=%b done=%b exp 0/0/0", dout4, busy4, done4); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0/0", busy1, done1); end
  endtask

  task automatic test_sll_max();
    logic [31:0] r; int lat; bit bok;
    op1(5'd31, 32'h0000_0001, 2'b00, r, lat, bok);
    checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL sll31_dout got=%h exp=80000000", r); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL sll31_latency got=%0d exp=32", lat); end
    checks++; if (!bok) begin failures++; $display("FAIL sll31_busy got=low_in_window exp=high_edges_0_31"); end
    checks++; if (busy1 !== 1'b0 || ready1 !== 1'b1) begin
      failures++; $display("FAIL sll31_done_state got busy=%b ready=%b exp 0/1", busy1, ready1); end
  endtask

  task automatic test_sra_srl();
    logic [31:0] r; int lat; bit bok;
    op1(5'd4, 32'h8000_0000, 2'b10, r, lat, bok);
    checks++; if (r !== 32'hF800_0000) begin failures++; $display("FAIL sra4_dout got=%h exp=f8000000", r); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL sra4_latency got=%0d exp=5", lat); end
    op1(5'd4, 32'h8000_0000, 2'b01, r, lat, bok);
    checks++; if (r !== 32'h0800_0000) begin failures++; $display("FAIL srl4_dout got=%h exp=08000000", r); end
  endtask

  task automatic test_ror_zero();
    logic [31:0] r; int lat; bit bok;
    op1(5'd4, 32'h0000_00F1, 2'b11, r, lat, bok);
    checks++; if (r !== 32'h1000_000F) begin failures++; $display("FAIL ror4_dout got=%h exp=1000000f", r); end
    for (int m = 0; m < 4; m++) begin
      op1(5'd0, 32'hDEAD_BEEF, 2'(m), r, lat, bok);
      checks++; if (r !== 32'hDEAD_BEEF) begin failures++; $display("FAIL a0_mode%0d_dout got=%h exp=deadbeef", m, r); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL a0_mode%0d_latency got=%0d exp=1", m, lat); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start1 = 1'b1; a1 = 5'd8; b1 = 32'h0000_0003; ctrl1 = 2'b00;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start1 = 1'b1; a1 = 5'd1; b1 = 32'h0000_FFFF; ctrl1 = 2'b01;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = -1;
    for (int e = 4; e <= 100; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin lat = e; break; end
    end
    checks++; if (dout1 !== 32'h0000_0300) begin failures++; $display("FAIL busy_ignore_dout got=%h exp=00000300", dout1); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=9", lat); end
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done1); end
    checks++; if (dout1 !== 32'h0000_0300) begin failures++; $display("FAIL dout_hold got=%h exp=00000300", dout1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; bit bok;
    op1(5'd4, 32'h0000_0100, 2'b01, r, lat, bok);
    checks++; if (r !== 32'h0000_0010) begin failures++; $display("FAIL b2b_first got=%h exp=00000010", r); end
    // Now in the DONE cycle: hold start so the next edge accepts directly.
    start1 = 1'b1; a1 = 5'd2; b1 = 32'h0000_0001; ctrl1 = 2'b00;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      failures++; $display("FAIL b2b_no_idle got busy=%b done=%b exp 1/0", busy1, done1); end
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin lat = e; break; end
    end
    checks++; if (dout1 !== 32'h0000_0004) begin failures++; $display("FAIL b2b_second got=%h exp=00000004", dout1); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; bit bok; bit saw_done;
    @(negedge clk);
    start1 = 1'b1; a1 = 5'd20; b1 = 32'h0000_0001; ctrl1 = 2'b00;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (dout1 !== 32'h0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++; $display("FAIL mid_reset got dout=%h busy=%b done=%b exp 0/0/0", dout1, busy1, done1); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL mid_reset_aborted got=activity exp=none"); end
    op1(5'd8, 32'h1234_5678, 2'b11, r, lat, bok);
    checks++; if (r !== 32'h7812_3456) begin failures++; $display("FAIL post_reset_dout got=%h exp=78123456", r); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL post_reset_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_step4();
    logic [31:0] r, b, exp_r; logic [4:0] a; logic [1:0] c; int lat, exp_lat;
    op4(5'd5, 32'h0000_0001, 2'b00, r, lat);
    checks++; if (r !== 32'h0000_0020) begin failures++; $display("FAIL step4_sll5_dout got=%h exp=00000020", r); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL step4_sll5_latency got=%0d exp=3", lat); end
    op4(5'd31, 32'h8000_0001, 2'b10, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL step4_sra31_dout got=%h exp=ffffffff", r); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL step4_sra31_latency got=%0d exp=9", lat); end
    for (int i = 0; i < 24; i++) begin
      a = 5'($urandom_range(0, 31));
      b = $urandom;
      c = 2'(i % 4);
      exp_r = model(b, int'(a), c);
      exp_lat = (int'(a) + 3) / 4 + 1;
      op4(a, b, c, r, lat);
      checks++; if (r !== exp_r) begin failures++; $display("FAIL step4_rand%0d_dout got=%h exp=%h (a=%0d b=%h c=%0d)", i, r, exp_r, a, b, c); end
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL step4_rand%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_step1_random();
    logic [31:0] r, b, exp_r; logic [4:0] a; logic [1:0] c; int lat; bit bok;
    for (int i = 0; i < 8; i++) begin
      a = 5'($urandom_range(0, 31));
      b = $urandom;
      c = 2'(i % 4);
      exp_r = model(b, int'(a), c);
      op1(a, b, c, r, lat, bok);
      checks++; if (r !== exp_r) begin failures++; $display("FAIL step1_rand%0d_dout got=%h exp=%h (a=%0d b=%h c=%0d)", i, r, exp_r, a, b, c); end
      checks++; if (lat !== int'(a) + 1) begin failures++; $display("FAIL step1_rand%0d_latency got=%0d exp=%0d", i, lat, int'(a) + 1); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ctrl1 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0; ctrl4 = '0;
    test_reset();
    test_sll_max();
    test_sra_srl();
    test_ror_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_step4();
    test_step1_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
